// File: rtl/autotest_feed_responder.sv
// autotest_feed_responder
// Stand-in responder for the autotest feed protocol. Absorbs fed words with a
// fixed busy window per word. On a stop request it runs a finalisation
// countdown and then presents the shift-in of all accepted words with end_uut
// held high.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   clear       synchronous clear, same effect as rst on the next edge
//   feed_data   word to absorb, sampled with data_ready
//   data_ready  single-cycle feed strobe
//   stop_feed   single-cycle finalise strobe
//   busy        responder cannot accept a word
//   end_uut     result valid, held until rst/clear
//   err         sticky protocol-violation flag
//   word_count  accepted words, saturating
//   result      shift register of accepted words, newest in the LSBs
module autotest_feed_responder #(
  parameter int unsigned FEED_DATA_SIZE = 8,
  parameter int unsigned OUTPUT_SIZE    = 88,
  parameter int unsigned BUSY_CYCLES    = 2,
  parameter int unsigned FINAL_CYCLES   = 45,
  parameter int unsigned COUNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [FEED_DATA_SIZE-1:0] feed_data,
  input  logic                      data_ready,
  input  logic                      stop_feed,
  output logic                      busy,
  output logic                      end_uut,
  output logic                      err,
  output logic [COUNT_W-1:0]        word_count,
  output logic [OUTPUT_SIZE-1:0]    result
);

  localparam int unsigned TIMER_W = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ABSORB = 2'd1;
  localparam logic [1:0] S_FINAL  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]                r_state;
  logic [TIMER_W-1:0]        r_timer;
  logic                      r_busy;
  logic                      r_end;
  logic                      r_err;
  logic                      r_stop_pend;
  logic [COUNT_W-1:0]        r_count;
  logic [OUTPUT_SIZE-1:0]    r_result;

  logic [1:0]                w_state;
  logic [TIMER_W-1:0]        w_timer;
  logic                      w_busy;
  logic                      w_end;
  logic                      w_err;
  logic                      w_stop_pend;
  logic [COUNT_W-1:0]        w_count;
  logic [OUTPUT_SIZE-1:0]    w_result;
  logic                      w_stop_any;

  // Stop seen either earlier in this busy window or on this very cycle.
  assign w_stop_any = r_stop_pend | stop_feed;

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_busy      <= 1'b0;
      r_end       <= 1'b0;
      r_err       <= 1'b0;
      r_stop_pend <= 1'b0;
      r_count     <= '0;
      r_result    <= '0;
    end else begin
      r_state     <= w_state;
      r_timer     <= w_timer;
      r_busy      <= w_busy;
      r_end       <= w_end;
      r_err       <= w_err;
      r_stop_pend <= w_stop_pend;
      r_count     <= w_count;
      r_result    <= w_result;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state     = r_state;
    w_timer     = r_timer;
    w_busy      = r_busy;
    w_end       = r_end;
    w_err       = r_err;
    w_stop_pend = r_stop_pend;
    w_count     = r_count;
    w_result    = r_result;

    if (clear) begin
      w_state     = S_IDLE;
      w_timer     = '0;
      w_busy      = 1'b0;
      w_end       = 1'b0;
      w_err       = 1'b0;
      w_stop_pend = 1'b0;
      w_count     = '0;
      w_result    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_ready) begin
            // Concatenate then truncate: the oldest word falls off the MSB end.
            w_result    = OUTPUT_SIZE'({r_result, feed_data});
            if (r_count != {COUNT_W{1'b1}}) begin
              w_count = r_count + COUNT_W'(1);
            end
            w_timer     = TIMER_W'(BUSY_CYCLES);
            w_busy      = 1'b1;
            w_stop_pend = stop_feed;
            w_state     = S_ABSORB;
          end else if (stop_feed) begin
            w_timer = TIMER_W'(FINAL_CYCLES);
            w_busy  = 1'b1;
            w_state = S_FINAL;
          end
        end

        S_ABSORB: begin
          if (data_ready) begin
            w_err = 1'b1;
          end
          if (stop_feed) begin
            w_stop_pend = 1'b1;
          end
          if (r_timer <= TIMER_W'(1)) begin
            if (w_stop_any) begin
              // busy stays high straight into finalisation.
              w_timer     = TIMER_W'(FINAL_CYCLES);
              w_stop_pend = 1'b0;
              w_state     = S_FINAL;
            end else begin
              w_timer = '0;
              w_busy  = 1'b0;
              w_state = S_IDLE;
            end
          end else begin
            w_timer = r_timer - TIMER_W'(1);
          end
        end

        S_FINAL: begin
          if (data_ready || stop_feed) begin
            w_err = 1'b1;
          end
          if (r_timer <= TIMER_W'(1)) begin
            w_timer = '0;
            w_busy  = 1'b0;
            w_end   = 1'b1;
            w_state = S_DONE;
          end else begin
            w_timer = r_timer - TIMER_W'(1);
          end
        end

        S_DONE: begin
          if (data_ready || stop_feed) begin
            w_err = 1'b1;
          end
          w_busy = 1'b0;
          w_end  = 1'b1;
        end

        default: begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign end_uut    = r_end;
  assign err        = r_err;
  assign word_count = r_count;
  assign result     = r_result;

endmodule

// File: tb/tb_autotest_feed_responder.sv
// Scoreboard bench for autotest_feed_responder. A driver issues sessions of fed
// words and a stop; at each stop the reference outcome is queued, and a
// monitor pops and compares it when end_uut rises.
module tb_autotest_feed_responder;

  localparam int unsigned FD = 8;
  localparam int unsigned OS = 88;
  localparam int unsigned BC = 2;
  localparam int unsigned FC = 45;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [FD-1:0] feed_data;
  logic          data_ready;
  logic          stop_feed;
  logic          busy;
  logic          end_uut;
  logic          err;
  logic [CW-1:0] word_count;
  logic [OS-1:0] result;

  always #5 clk = ~clk;

  autotest_feed_responder #(
    .FEED_DATA_SIZE(FD),
    .OUTPUT_SIZE   (OS),
    .BUSY_CYCLES   (BC),
    .FINAL_CYCLES  (FC),
    .COUNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .feed_data  (feed_data),
    .data_ready (data_ready),
    .stop_feed  (stop_feed),
    .busy       (busy),
    .end_uut    (end_uut),
    .err        (err),
    .word_count (word_count),
    .result     (result)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OS-1:0] res;
    logic [CW-1:0] cnt;
    logic          err;
    int            stop_cyc;
    int            lat;
  } exp_t;

  exp_t q[$];

  // Reference model: a plain number that grows by shifting one word in.
  logic [OS-1:0] m_res;
  int            m_n;
  logic          m_err;

  function automatic void model_reset();
    m_res = '0;
    m_n   = 0;
    m_err = 1'b0;
  endfunction

  function automatic void model_absorb(input logic [FD-1:0] w);
    m_res = (m_res << FD) | OS'(w);
    m_n   = m_n + 1;
  endfunction

  function automatic logic [CW-1:0] model_cnt();
    int mx;
    mx = (1 << CW) - 1;
    return CW'((m_n > mx) ? mx : m_n);
  endfunction

  task automatic chk(input string name, input logic [OS-1:0] act, input logic [OS-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},   OS'(busy),       OS'(0));
    chk({tag, "_end"},    OS'(end_uut),    OS'(0));
    chk({tag, "_err"},    OS'(err),        OS'(0));
    chk({tag, "_count"},  OS'(word_count), OS'(0));
    chk({tag, "_result"}, result,          OS'(0));
  endtask

  // Monitor: compare every rising end_uut against the oldest queued outcome.
  logic prev_end = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (end_uut && !prev_end) begin
      if (q.size() == 0) begin
        chk("unexpected_end", OS'(1), OS'(0));
      end else begin
        e = q.pop_front();
        chk("mon_result",  result,          e.res);
        chk("mon_count",   OS'(word_count), OS'(e.cnt));
        chk("mon_err",     OS'(err),        OS'(e.err));
        chk("mon_busy",    OS'(busy),       OS'(0));
        chk("mon_latency", OS'(cyc - e.stop_cyc + 1), OS'(e.lat));
      end
    end
    prev_end = end_uut;
  end

  // Feed one word from IDLE; optionally strobe a second word inside the busy window.
  task automatic feed(input logic [FD-1:0] w, input logic viol, input logic [FD-1:0] w2);
    int n;
    @(negedge clk);
    feed_data  = w;
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
    model_absorb(w);
    n = 0;
    while (busy && n < 600) begin
      n = n + 1;
      if (viol && n == 1) begin
        feed_data  = w2;
        data_ready = 1'b1;
        m_err      = 1'b1;
      end
      @(posedge clk);
      #1;
      data_ready = 1'b0;
    end
    chk("busy_len", OS'(n), OS'(BC));
  endtask

  // Stop strobe (alone or together with a last word); queue the outcome and wait for end.
  task automatic stop_and_wait(input logic push, input logic comb, input logic [FD-1:0] w);
    exp_t e;
    int   n;
    int   bc;
    @(negedge clk);
    stop_feed = 1'b1;
    if (comb) begin
      feed_data  = w;
      data_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    stop_feed  = 1'b0;
    data_ready = 1'b0;
    if (comb) model_absorb(w);
    if (push) begin
      e.res      = m_res;
      e.cnt      = model_cnt();
      e.err      = m_err;
      e.stop_cyc = cyc;
      e.lat      = comb ? int'(BC + FC + 1) : int'(FC + 1);
      q.push_back(e);
      n  = 0;
      bc = 0;
      while (!end_uut && n < 1000) begin
        if (busy) bc = bc + 1;
        @(posedge clk);
        #1;
        n = n + 1;
      end
      chk("end_timeout", OS'(end_uut), OS'(1));
      chk("busy_final_len", OS'(bc), comb ? OS'(BC + FC) : OS'(FC));
    end
  endtask

  // Strobe in DONE: must be ignored apart from raising err.
  task automatic poke_done();
    @(negedge clk);
    feed_data  = FD'($urandom);
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
    chk("poke_err",    OS'(err),        OS'(1));
    chk("poke_result", result,          m_res);
    chk("poke_count",  OS'(word_count), OS'(model_cnt()));
    chk("poke_end",    OS'(end_uut),    OS'(1));
  endtask

  // Synchronous clear from DONE, optionally with a competing strobe.
  task automatic clr_reset(input logic with_strobe);
    @(negedge clk);
    clear = 1'b1;
    if (with_strobe) begin
      feed_data  = FD'($urandom);
      data_ready = 1'b1;
      stop_feed  = 1'($urandom_range(0, 1));
    end
    #1;
    chk("clear_pre_edge_end", OS'(end_uut), OS'(1));
    @(posedge clk);
    #1;
    clear      = 1'b0;
    data_ready = 1'b0;
    stop_feed  = 1'b0;
    check_zero("clear");
    model_reset();
  endtask

  initial begin
    int   n;
    logic comb;

    rst        = 1'b1;
    clear      = 1'b0;
    feed_data  = '0;
    data_ready = 1'b0;
    stop_feed  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Three words then a separate stop.
    feed(8'hA5, 1'b0, 8'h00);
    feed(8'h3C, 1'b0, 8'h00);
    feed(8'h01, 1'b0, 8'h00);
    stop_and_wait(1'b1, 1'b0, 8'h00);
    clr_reset(1'b0);

    // Twelve words: only the last eleven survive.
    for (int i = 1; i <= 12; i++) feed(FD'(i), 1'b0, 8'h00);
    stop_and_wait(1'b1, 1'b0, 8'h00);
    clr_reset(1'b0);

    // Word strobed while busy is dropped and flagged.
    feed(8'h11, 1'b1, 8'h22);
    chk("viol_err",   OS'(err),        OS'(1));
    chk("viol_count", OS'(word_count), OS'(1));
    chk("viol_lsb",   OS'(result[7:0]), OS'(8'h11));
    stop_and_wait(1'b1, 1'b0, 8'h00);
    clr_reset(1'b0);

    // Combined last-word + stop strobe.
    stop_and_wait(1'b1, 1'b1, 8'h77);
    clr_reset(1'b0);

    // Stop with no data, then a strobe in DONE.
    stop_and_wait(1'b1, 1'b0, 8'h00);
    poke_done();
    clr_reset(1'b1);

    // Asynchronous reset in the middle of finalisation.
    feed(8'h33, 1'b0, 8'h00);
    stop_and_wait(1'b0, 1'b0, 8'h00);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Fresh run after reset, then clear from DONE.
    feed(8'h5A, 1'b0, 8'h00);
    stop_and_wait(1'b1, 1'b0, 8'h00);
    clr_reset(1'b1);
    feed(8'h5A, 1'b0, 8'h00);
    stop_and_wait(1'b1, 1'b0, 8'h00);
    clr_reset(1'b0);

    // Counter saturation.
    for (int i = 0; i < 35; i++) feed(FD'($urandom), 1'b0, 8'h00);
    stop_and_wait(1'b1, 1'b0, 8'h00);
    clr_reset(1'b0);

    // Randomised sessions.
    for (int s = 0; s < 20; s++) begin
      n    = int'($urandom_range(0, 40));
      comb = (n > 0) && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < n - (comb ? 1 : 0); i++) begin
        feed(FD'($urandom), 1'($urandom_range(0, 7) == 0), FD'($urandom));
      end
      stop_and_wait(1'b1, comb, FD'($urandom));
      if ($urandom_range(0, 3) == 0) poke_done();
      clr_reset(1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", OS'(q.size()), OS'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/autotest_feed_responder.md
Name: autotest_feed_responder

Overview:
- UUT-side model of the autotest feed protocol. It is the responder that `autotest_feed_module` drives in place of a real core such as `spongent_iter`.
- Absorbs fed words with a configurable busy handshake and finalises on a stop request. It then presents a deterministic output, the shift-in of all accepted words, and asserts end.
- Used to self-test the autotest harness and SD/SPI flow on the board without a cipher in the loop.

Parameters:
- FEED_DATA_SIZE, 8: width of one fed word.
- OUTPUT_SIZE, 88: width of the result register. Must be >= FEED_DATA_SIZE.
- BUSY_CYCLES, 2: cycles busy stays high after each accepted word. Range 1..255.
- FINAL_CYCLES, 45: cycles busy stays high after stop before end. Range 1..255.
- COUNT_W, 16: width of the accepted-word counter.

Ports:
- clk, in, 1: system clock. All logic is on the rising edge.
- rst, in, 1: asynchronous active-high reset.
- clear, in, 1: synchronous clear. Same effect as rst, applied on the next edge.
- feed_data, in, FEED_DATA_SIZE: word to absorb. Sampled when data_ready=1.
- data_ready, in, 1: single-cycle feed strobe.
- stop_feed, in, 1: single-cycle "no more data, finalise" strobe.
- busy, out, 1: responder cannot accept a word.
- end_uut, out, 1: result valid. Level, held until rst/clear.
- err, out, 1: sticky protocol-violation flag.
- word_count, out, COUNT_W: number of words accepted. Saturates at all-ones.
- result, out, OUTPUT_SIZE: shift register of accepted words, newest in the LSBs.

Behaviour:
- Reset (rst or clear): state=IDLE, busy=0, end_uut=0, err=0, word_count=0, result=0, stop_pending=0, timer=0.
- States: IDLE, ABSORB, FINAL, DONE.
- IDLE, data_ready=1:
  - result <= {result[OUTPUT_SIZE-FEED_DATA_SIZE-1:0], feed_data}; oldest bits drop off the MSB end.
  - word_count increments.
  - timer <= BUSY_CYCLES; go to ABSORB.
  - busy is registered: it rises the cycle after the strobe and stays high exactly BUSY_CYCLES cycles.
- IDLE, stop_feed=1 with data_ready=0: timer <= FINAL_CYCLES; go to FINAL. busy rises the next cycle.
- IDLE, data_ready and stop_feed together: word is absorbed first, stop_pending <= 1, go to ABSORB.
- ABSORB: timer decrements each cycle. When it reaches 1 the next state is IDLE, or FINAL if stop_pending (timer reloads FINAL_CYCLES, stop_pending clears). busy stays continuously high through the ABSORB->FINAL transition.
- ABSORB, data_ready=1: word dropped, err <= 1, no count change.
- ABSORB, stop_feed=1: stop_pending <= 1. Not an error.
- FINAL: timer decrements. On expiry go to DONE; end_uut=1 and busy=0 on the same cycle. result and word_count are frozen from FINAL entry.
- FINAL or DONE, data_ready=1: ignored, err <= 1.
- FINAL or DONE, stop_feed=1: ignored, err <= 1.
- DONE: holds result, end_uut=1, busy=0 until rst/clear.
- Stop with zero words: legal. Result=0, word_count=0, end_uut after FINAL_CYCLES.
- word_count saturates at 2^COUNT_W-1. Absorbing still shifts result.
- rst mid-operation: all outputs go to reset values immediately (asynchronous).
- clear mid-operation: all outputs go to reset values on the next edge and override any simultaneous strobe.
- Latency from the stop strobe in IDLE to end_uut rising: FINAL_CYCLES+1 edges. From a combined last-word+stop strobe: BUSY_CYCLES+FINAL_CYCLES+1 edges.

Test Plan:
1. Reset, then feed 0xA5, 0x3C, 0x01 (waiting for busy=0 each time), then stop -> result=88'h00...A53C01, word_count=3, err=0. busy high exactly 2 cycles per word; end_uut rises 46 edges after the stop strobe.
2. Feed 12 words 0x01..0x0C, then stop -> result holds the last 11 words: 88'h02030405060708090A0B0C. word_count=12.
3. Feed 0x11, then strobe data_ready=0x22 while busy=1 -> 0x22 dropped, err=1, word_count=1, result LSB byte=0x11.
4. Combined strobe data_ready=0x77 + stop_feed in IDLE -> word absorbed, busy high continuously for 2+45 cycles, end_uut=1, result=...77, err=0.
5. Stop with no data -> end_uut after 45 busy cycles, result=0, word_count=0. A further data_ready in DONE -> err=1, result unchanged.
6. Assert rst mid-FINAL, then clear in DONE on a separate run -> all outputs 0 at once (rst) or on the next edge (clear). A fresh feed of 0x5A then stop -> result=...5A, word_count=1.
